// File: rtl/quadrature_input_if.sv
// rtl/quadrature_input_if.sv - encoder, button and position bundle for quadrature_input
interface quadrature_input_if #(
    parameter int NUM_CH    = 2,
    parameter int POS_WIDTH = 8
);
    logic [NUM_CH-1:0]           in_a;
    logic [NUM_CH-1:0]           in_b;
    logic [NUM_CH-1:0]           switch;
    logic [NUM_CH-1:0]           up;
    logic [NUM_CH-1:0]           down;
    logic [NUM_CH-1:0]           button;
    logic [NUM_CH-1:0]           press;
    logic [NUM_CH-1:0]           err;
    logic [NUM_CH*POS_WIDTH-1:0] pos;

    modport master (
        output in_a, in_b, switch,
        input  up, down, button, press, pos, err
    );

    modport slave (
        input  in_a, in_b, switch,
        output up, down, button, press, pos, err
    );
endinterface

// File: rtl/quadrature_input.sv
// rtl/quadrature_input.sv - multi-channel quadrature decoder with debounce, step pulses and position (optional QUAD_ERR_DETECT_EN)
module quadrature_input #(
    parameter int NUM_CH          = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int PULSES_PER_STEP = 1,
    parameter int POS_WIDTH       = 8,
    parameter int POS_MAX         = 200,
    parameter int POS_INIT        = 100
) (
    input logic               clk,
    input logic               reset,
    quadrature_input_if.slave bus
);
    localparam int ARM_CYCLES = 2 + DEBOUNCE_CYCLES;
    localparam int ARM_W      = $clog2(ARM_CYCLES + 1);
    localparam int DB_W       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SUB_W      = 4;
    localparam logic signed [SUB_W-1:0] STEP_P = SUB_W'(PULSES_PER_STEP);
    localparam logic signed [SUB_W-1:0] STEP_N = -STEP_P;

    logic [ARM_W-1:0]            arm_q;
    logic                        armed;
    logic [NUM_CH-1:0]           up_v, down_v, press_v, button_v, err_v;
    logic [NUM_CH*POS_WIDTH-1:0] pos_v;

    // Arm counter: hold off decoding until the input pipeline has refilled after reset
    always_ff @(posedge clk) begin
        if (reset)       arm_q <= '0;
        else if (!armed) arm_q <= arm_q + 1'b1;
    end
    assign armed = (arm_q == ARM_W'(ARM_CYCLES));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [2:0]                    raw, sync1_q, sync2_q, deb;
        logic [1:0]                    prev_q, cur_idx, prev_idx, diff;
        logic                          sw_prev_q;
        logic signed [SUB_W-1:0]       sub_q, sub_d, acc;
        logic                          up_q, up_d, down_q, down_d, press_q, press_d;
        logic [POS_WIDTH-1:0]          pos_q, pos_d;

        // bit 0 = A, bit 1 = B, bit 2 = push-button
        assign raw = {bus.switch[i], bus.in_b[i], bus.in_a[i]};

        // Two-flop synchroniser for the asynchronous raw inputs
        always_ff @(posedge clk) begin
            if (reset) begin
                sync1_q <= '0;
                sync2_q <= '0;
            end else begin
                sync1_q <= raw;
                sync2_q <= sync1_q;
            end
        end

        if (DEBOUNCE_CYCLES == 0) begin : g_nodb
            assign deb = sync2_q;
        end else begin : g_db
            for (genvar j = 0; j < 3; j++) begin : g_bit
                logic            stable_q, stable_d;
                logic [DB_W-1:0] cnt_q, cnt_d;

                // Accept a new level only after it has disagreed for DEBOUNCE_CYCLES cycles in a row
                always_comb begin
                    stable_d = stable_q;
                    cnt_d    = '0;
                    if (sync2_q[j] != stable_q) begin
                        if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) stable_d = sync2_q[j];
                        else                                     cnt_d    = cnt_q + 1'b1;
                    end
                end

                // Debouncer state register
                always_ff @(posedge clk) begin
                    if (reset) begin
                        stable_q <= 1'b0;
                        cnt_q    <= '0;
                    end else begin
                        stable_q <= stable_d;
                        cnt_q    <= cnt_d;
                    end
                end

                assign deb[j] = stable_q;
            end
        end

        // Gray position index: 00->0, 10->1, 11->2, 01->3 for {a,b}; +1 mod 4 is A-leading
        assign cur_idx  = {deb[1], deb[0] ^ deb[1]};
        assign prev_idx = {prev_q[1], prev_q[0] ^ prev_q[1]};
        assign diff     = cur_idx - prev_idx;

        // Step accumulation, pulse generation and saturating position update
        always_comb begin
            sub_d   = sub_q;
            acc     = sub_q;
            up_d    = 1'b0;
            down_d  = 1'b0;
            press_d = 1'b0;
            pos_d   = pos_q;
            if (armed) begin
                press_d = deb[2] & ~sw_prev_q;
                if (diff == 2'd1) begin
                    acc = (sub_q[SUB_W-1] ? '0 : sub_q) + SUB_W'(1);
                    if (acc == STEP_P) begin
                        up_d  = 1'b1;
                        sub_d = '0;
                    end else begin
                        sub_d = acc;
                    end
                end else if (diff == 2'd3) begin
                    acc = ((!sub_q[SUB_W-1] && sub_q != '0) ? '0 : sub_q) - SUB_W'(1);
                    if (acc == STEP_N) begin
                        down_d = 1'b1;
                        sub_d  = '0;
                    end else begin
                        sub_d = acc;
                    end
                end
                if (up_d && pos_q < POS_WIDTH'(POS_MAX)) pos_d = pos_q + 1'b1;
                if (down_d && pos_q != '0)               pos_d = pos_q - 1'b1;
            end
        end

        // Channel state and registered outputs; previous-state always tracks the debounced inputs
        always_ff @(posedge clk) begin
            if (reset) begin
                prev_q    <= '0;
                sw_prev_q <= 1'b0;
                sub_q     <= '0;
                up_q      <= 1'b0;
                down_q    <= 1'b0;
                press_q   <= 1'b0;
                pos_q     <= POS_WIDTH'(POS_INIT);
            end else begin
                prev_q    <= deb[1:0];
                sw_prev_q <= deb[2];
                sub_q     <= sub_d;
                up_q      <= up_d;
                down_q    <= down_d;
                press_q   <= press_d;
                pos_q     <= pos_d;
            end
        end

`ifdef QUAD_ERR_DETECT_EN
        logic err_q;
        // Sticky flag for a jump where both phases changed at once
        always_ff @(posedge clk) begin
            if (reset)                       err_q <= 1'b0;
            else if (armed && diff == 2'd2)  err_q <= 1'b1;
        end
        assign err_v[i] = err_q;
`else
        assign err_v[i] = 1'b0;
`endif

        assign up_v[i]                          = up_q;
        assign down_v[i]                        = down_q;
        assign press_v[i]                       = press_q;
        assign button_v[i]                      = deb[2];
        assign pos_v[i*POS_WIDTH +: POS_WIDTH]  = pos_q;
    end

    assign bus.up     = up_v;
    assign bus.down   = down_v;
    assign bus.press  = press_v;
    assign bus.button = button_v;
    assign bus.pos    = pos_v;
    assign bus.err    = err_v;
endmodule
